// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter between fetch and data stages
// Data wins ties; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    dm_read_enable,
  input  logic                    dm_write_enable,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_byte_en,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    fetch_stall,
  output logic                    mem_stall
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          dreq;
  logic          cnt_full;
  logic          done;

  assign dreq     = dm_read_enable | dm_write_enable;
  assign cnt_full = (starve_cnt == CW'(STARVE_LIMIT));
  assign done     = mem_req & mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !(if_req && cnt_full)) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_write_enable;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_byte_en;
            if (if_req && !cnt_full)
              starve_cnt <= starve_cnt + CW'(1);
          end else if (if_req) begin
            state      <= FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_be     <= '1;
            starve_cnt <= '0;
          end
        end
        default: begin
          // mem_* hold until the memory completes; one IDLE turnaround follows
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign if_valid    = done && (state == FETCH);
  assign dm_done     = done && (state == DATA);
  assign if_rdata    = mem_rdata;
  assign dm_rdata    = mem_rdata;
  assign fetch_stall = if_req & ~if_valid;
  assign mem_stall   = dreq & ~dm_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  typedef struct {
    bit          is_fetch;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_cyc;
    bit          b2b;
  } txn_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        if_req = 0;
  logic [31:0] if_addr = 0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_read_enable = 0;
  logic        dm_write_enable = 0;
  logic [31:0] dm_addr = 0;
  logic [31:0] dm_wdata = 0;
  logic [3:0]  dm_byte_en = 0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;
  logic        fetch_stall;
  logic        mem_stall;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int wcnt = 0;
  int cyc = 0;
  int idle_cnt = 0;
  bit f_done = 0;
  bit d_done = 0;

  txn_t        exp_q[$];
  txn_t        data_pend[$];
  logic [31:0] fetch_pend[$];

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byte_en(dm_byte_en),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00A00093 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic req_fetch(input logic [31:0] a);
    fetch_pend.push_back(a);
  endtask

  task automatic req_data(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    txn_t t;
    t = '{is_fetch: 0, rd: rd, wr: wr, addr: a, wdata: wd, be: be, wait_cyc: 0, b2b: 0};
    data_pend.push_back(t);
  endtask

  task automatic expect_f(input logic [31:0] a, input int w, input bit b2b);
    txn_t t;
    t = '{is_fetch: 1, rd: 1, wr: 0, addr: a, wdata: 0, be: 4'hF, wait_cyc: w, b2b: b2b};
    exp_q.push_back(t);
  endtask

  task automatic expect_d(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int w, input bit b2b);
    txn_t t;
    t = '{is_fetch: 0, rd: !wr, wr: wr, addr: a, wdata: wd, be: be, wait_cyc: w, b2b: b2b};
    exp_q.push_back(t);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && fetch_pend.size() == 0 && data_pend.size() == 0) break;
    end
    if (i == 300) begin
      chk("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete(); fetch_pend.delete(); data_pend.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Requesters and memory model: inputs change only on the falling edge
  always @(negedge clk) begin
    if (f_done) begin f_done = 0; if (fetch_pend.size() > 0) void'(fetch_pend.pop_front()); end
    if (d_done) begin d_done = 0; if (data_pend.size() > 0) void'(data_pend.pop_front()); end
    if_req  = (fetch_pend.size() > 0);
    if_addr = if_req ? fetch_pend[0] : 32'h0;
    if (data_pend.size() > 0) begin
      dm_read_enable  = data_pend[0].rd;
      dm_write_enable = data_pend[0].wr;
      dm_addr         = data_pend[0].addr;
      dm_wdata        = data_pend[0].wdata;
      dm_byte_en      = data_pend[0].be;
    end else begin
      dm_read_enable = 0; dm_write_enable = 0;
    end
    if (rst || !mem_req) begin
      mem_ready = 0; wcnt = 0; mem_rdata = $urandom;
    end else if (wcnt >= (exp_q.size() > 0 ? exp_q[0].wait_cyc : 0)) begin
      mem_ready = 1; mem_rdata = model_rdata(mem_addr);
    end else begin
      mem_ready = 0; wcnt++; mem_rdata = $urandom;
    end
  end

  // Monitor: samples just before each rising edge
  always begin
    txn_t cur;
    bit   have, done_now, exp_ifv, exp_dmd;
    @(negedge clk); #4;
    if (rst) begin
      cyc = 0; idle_cnt = 0;
    end else begin
      have = (exp_q.size() > 0);
      cur = have ? exp_q[0] : '{0, 0, 0, 0, 0, 0, 0, 0};
      done_now = mem_req && mem_ready;
      exp_ifv = 0; exp_dmd = 0;
      if (mem_req) begin
        if (!have) chk("spurious_req", 32'(mem_req), 32'd0);
        else begin
          if (cyc == 0 && cur.b2b) chk("turnaround", 32'(idle_cnt), 32'd1);
          cyc++;
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_we", 32'(mem_we), 32'(cur.wr));
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
          exp_ifv = done_now && cur.is_fetch;
          exp_dmd = done_now && !cur.is_fetch;
        end
        idle_cnt = 0;
      end else idle_cnt++;
      chk("if_valid", 32'(if_valid), 32'(exp_ifv));
      chk("dm_done", 32'(dm_done), 32'(exp_dmd));
      chk("fetch_stall", 32'(fetch_stall), 32'(if_req && !exp_ifv));
      chk("mem_stall", 32'(mem_stall), 32'((dm_read_enable || dm_write_enable) && !exp_dmd));
      if (done_now && have) begin
        if (cur.is_fetch) chk("if_rdata", if_rdata, model_rdata(cur.addr));
        else if (!cur.wr) chk("dm_rdata", dm_rdata, model_rdata(cur.addr));
        chk("req_cycles", 32'(cyc), 32'(cur.wait_cyc + 1));
        void'(exp_q.pop_front());
        cyc = 0;
        n_done++;
        if (cur.is_fetch) f_done = 1; else d_done = 1;
      end
    end
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // Lone fetch with two wait cycles
    req_fetch(32'h100);
    expect_f(32'h100, 2, 0);
    wait_idle();

    // Load and fetch raised together: data first, fetch after one turnaround
    req_fetch(32'h400);
    req_data(1, 0, 32'h2000, 32'h0, 4'hF);
    expect_d(0, 32'h2000, 32'h0, 4'hF, 0, 0);
    expect_f(32'h400, 1, 1);
    wait_idle();

    // Starvation: four data grants, forced fetch, counter cleared so data wins again
    req_fetch(32'h300);
    req_fetch(32'h304);
    for (int k = 0; k < 6; k++) req_data(1, 0, 32'h3000 + 32'(4 * k), 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) expect_d(0, 32'h3000 + 32'(4 * k), 32'h0, 4'hF, 0, k != 0);
    expect_f(32'h300, 0, 1);
    expect_d(0, 32'h3010, 32'h0, 4'hF, 0, 1);
    expect_d(0, 32'h3014, 32'h0, 4'hF, 0, 1);
    expect_f(32'h304, 0, 1);
    wait_idle();

    // Partial store held across wait cycles
    req_data(0, 1, 32'h2004, 32'hDEADBEEF, 4'b0011);
    expect_d(1, 32'h2004, 32'hDEADBEEF, 4'b0011, 2, 0);
    wait_idle();

    // Read and write both high is a write
    req_data(1, 1, 32'h2008, 32'h12345678, 4'hF);
    expect_d(1, 32'h2008, 32'h12345678, 4'hF, 0, 0);
    wait_idle();

    // Reset while a data access is waiting on the memory
    req_data(1, 0, 32'h2100, 32'h0, 4'hF);
    expect_d(0, 32'h2100, 32'h0, 4'hF, 3, 0);
    for (i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (mem_req) break;
    end
    chk("rst_mid_granted", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mid_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mid_dm_done", 32'(dm_done), 32'd0);
    rst = 0;
    wait_idle();

    chk("total_done", 32'(n_done), 32'd14);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
